// File: rtl/true_dual_port_bram.sv
// True dual-port block RAM with byte-lane writes, selectable read-during-write
// behaviour, optional output register, collision flag and post-reset clear.
module true_dual_port_bram #(
  parameter int unsigned p_ADDRESS_WIDTH  = 4,
  parameter int unsigned p_DATA_WIDTH     = 32,
  parameter int unsigned p_BYTE_WIDTH     = 8,
  parameter int unsigned p_READ_MODE      = 0,
  parameter int unsigned p_OUTPUT_REG     = 0,
  parameter int unsigned p_CLEAR_ON_RESET = 1
) (
  input  logic                                   i_CLK,
  input  logic                                   i_RESET,
  output logic                                   o_INIT_BUSY,
  output logic                                   o_COLLISION,
  input  logic                                   i_ENABLE_A,
  input  logic [p_DATA_WIDTH/p_BYTE_WIDTH-1:0]   i_WRITE_ENABLE_A,
  input  logic [p_ADDRESS_WIDTH-1:0]             i_ADDRESS_A,
  input  logic [p_DATA_WIDTH-1:0]                i_WRITE_DATA_A,
  output logic [p_DATA_WIDTH-1:0]                o_READ_DATA_A,
  output logic                                   o_READ_VALID_A,
  input  logic                                   i_ENABLE_B,
  input  logic [p_DATA_WIDTH/p_BYTE_WIDTH-1:0]   i_WRITE_ENABLE_B,
  input  logic [p_ADDRESS_WIDTH-1:0]             i_ADDRESS_B,
  input  logic [p_DATA_WIDTH-1:0]                i_WRITE_DATA_B,
  output logic [p_DATA_WIDTH-1:0]                o_READ_DATA_B,
  output logic                                   o_READ_VALID_B
);

  localparam int unsigned p_LANES     = p_DATA_WIDTH / p_BYTE_WIDTH;
  localparam int unsigned DEPTH       = 1 << p_ADDRESS_WIDTH;
  localparam int unsigned READ_FIRST  = 0;
  localparam int unsigned WRITE_FIRST = 1;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  function automatic logic [p_DATA_WIDTH-1:0] merge_lanes(
    input logic [p_DATA_WIDTH-1:0] old_word,
    input logic [p_DATA_WIDTH-1:0] wr_word,
    input logic [p_LANES-1:0]      lane_en
  );
    merge_lanes = old_word;
    for (int unsigned l = 0; l < p_LANES; l++) begin
      if (lane_en[l]) merge_lanes[l*p_BYTE_WIDTH +: p_BYTE_WIDTH] = wr_word[l*p_BYTE_WIDTH +: p_BYTE_WIDTH];
    end
  endfunction

  logic [p_DATA_WIDTH-1:0]    mem_q [DEPTH];
  state_t                     state_q, state_d;
  logic [p_ADDRESS_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                       busy_q, busy_d;
  logic                       clr_we_c;
  logic                       coll_q, coll_d;
  logic [p_DATA_WIDTH-1:0]    rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic                       rv_a_q, rv_a_d, rv_b_q, rv_b_d;

  logic                    acc_a_c, acc_b_c, wr_a_c, wr_b_c;
  logic [p_DATA_WIDTH-1:0] old_a_c, old_b_c;

  // Clear sequencer state register
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_q   <= (p_CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      clr_cnt_q <= '0;
      busy_q    <= (p_CLEAR_ON_RESET != 0);
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
    end
  end

  // Walk every address writing zero, then hand the ports over
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we_c  = 1'b0;
    if (state_q == S_CLEAR) begin
      clr_we_c  = 1'b1;
      clr_cnt_d = clr_cnt_q + p_ADDRESS_WIDTH'(1);
      if (&clr_cnt_q) state_d = S_RUN;
    end
    busy_d = (state_d == S_CLEAR);
  end

  assign acc_a_c = i_ENABLE_A & ~busy_q;
  assign acc_b_c = i_ENABLE_B & ~busy_q;
  assign wr_a_c  = |i_WRITE_ENABLE_A;
  assign wr_b_c  = |i_WRITE_ENABLE_B;
  assign old_a_c = mem_q[i_ADDRESS_A];
  assign old_b_c = mem_q[i_ADDRESS_B];

  // Port B lanes are assigned first so port A wins overlapping lanes
  always_ff @(posedge i_CLK) begin
    if (clr_we_c) mem_q[clr_cnt_q] <= '0;
    for (int unsigned l = 0; l < p_LANES; l++) begin
      if (acc_b_c && i_WRITE_ENABLE_B[l])
        mem_q[i_ADDRESS_B][l*p_BYTE_WIDTH +: p_BYTE_WIDTH] <= i_WRITE_DATA_B[l*p_BYTE_WIDTH +: p_BYTE_WIDTH];
    end
    for (int unsigned l = 0; l < p_LANES; l++) begin
      if (acc_a_c && i_WRITE_ENABLE_A[l])
        mem_q[i_ADDRESS_A][l*p_BYTE_WIDTH +: p_BYTE_WIDTH] <= i_WRITE_DATA_A[l*p_BYTE_WIDTH +: p_BYTE_WIDTH];
    end
  end

  // First read stage; data holds when no new result is produced
  always_comb begin
    rd_a_d = rd_a_q;
    rv_a_d = 1'b0;
    rd_b_d = rd_b_q;
    rv_b_d = 1'b0;
    if (acc_a_c) begin
      if (!wr_a_c || p_READ_MODE == READ_FIRST) begin
        rd_a_d = old_a_c;
        rv_a_d = 1'b1;
      end else if (p_READ_MODE == WRITE_FIRST) begin
        rd_a_d = merge_lanes(old_a_c, i_WRITE_DATA_A, i_WRITE_ENABLE_A);
        rv_a_d = 1'b1;
      end
    end
    if (acc_b_c) begin
      if (!wr_b_c || p_READ_MODE == READ_FIRST) begin
        rd_b_d = old_b_c;
        rv_b_d = 1'b1;
      end else if (p_READ_MODE == WRITE_FIRST) begin
        rd_b_d = merge_lanes(old_b_c, i_WRITE_DATA_B, i_WRITE_ENABLE_B);
        rv_b_d = 1'b1;
      end
    end
    coll_d = acc_a_c && acc_b_c && (i_ADDRESS_A == i_ADDRESS_B)
             && (|(i_WRITE_ENABLE_A & i_WRITE_ENABLE_B));
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      rd_a_q <= '0;
      rv_a_q <= 1'b0;
      rd_b_q <= '0;
      rv_b_q <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      rd_a_q <= rd_a_d;
      rv_a_q <= rv_a_d;
      rd_b_q <= rd_b_d;
      rv_b_q <= rv_b_d;
      coll_q <= coll_d;
    end
  end

  assign o_INIT_BUSY = busy_q;
  assign o_COLLISION = coll_q;

  if (p_OUTPUT_REG != 0) begin : g_out_reg
    logic [p_DATA_WIDTH-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
    logic                    ov_a_q, ov_a_d, ov_b_q, ov_b_d;

    always_comb begin
      out_a_d = rd_a_q;
      ov_a_d  = rv_a_q;
      out_b_d = rd_b_q;
      ov_b_d  = rv_b_q;
    end

    always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
        out_a_q <= '0;
        ov_a_q  <= 1'b0;
        out_b_q <= '0;
        ov_b_q  <= 1'b0;
      end else begin
        out_a_q <= out_a_d;
        ov_a_q  <= ov_a_d;
        out_b_q <= out_b_d;
        ov_b_q  <= ov_b_d;
      end
    end

    assign o_READ_DATA_A  = out_a_q;
    assign o_READ_VALID_A = ov_a_q;
    assign o_READ_DATA_B  = out_b_q;
    assign o_READ_VALID_B = ov_b_q;
  end else begin : g_no_out_reg
    assign o_READ_DATA_A  = rd_a_q;
    assign o_READ_VALID_A = rv_a_q;
    assign o_READ_DATA_B  = rd_b_q;
    assign o_READ_VALID_B = rv_b_q;
  end

endmodule

// File: tb/tb_true_dual_port_bram.sv
// Bench for true_dual_port_bram: four instances (READ_FIRST, WRITE_FIRST,
// NO_CHANGE, READ_FIRST+output register) driven in lockstep against one model.
module tb_true_dual_port_bram;

  localparam int NI    = 4;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic [3:0]  we_a = '0, we_b = '0;
  logic [3:0]  addr_a = '0, addr_b = '0;
  logic [31:0] wd_a = '0, wd_b = '0;

  logic [31:0] rd_a [NI];
  logic [31:0] rd_b [NI];
  logic        rv_a [NI];
  logic        rv_b [NI];
  logic        busy [NI];
  logic        coll [NI];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic int mode_of(input int k);
    return (k == 3) ? 0 : k;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  for (genvar k = 0; k < NI; k++) begin : g_dut
    true_dual_port_bram #(
      .p_ADDRESS_WIDTH(4), .p_DATA_WIDTH(32), .p_BYTE_WIDTH(8),
      .p_READ_MODE((k == 3) ? 0 : k), .p_OUTPUT_REG((k == 3) ? 1 : 0),
      .p_CLEAR_ON_RESET(1)
    ) u_dut (
      .i_CLK(clk), .i_RESET(rst),
      .o_INIT_BUSY(busy[k]), .o_COLLISION(coll[k]),
      .i_ENABLE_A(en_a), .i_WRITE_ENABLE_A(we_a), .i_ADDRESS_A(addr_a),
      .i_WRITE_DATA_A(wd_a), .o_READ_DATA_A(rd_a[k]), .o_READ_VALID_A(rv_a[k]),
      .i_ENABLE_B(en_b), .i_WRITE_ENABLE_B(we_b), .i_ADDRESS_B(addr_b),
      .i_WRITE_DATA_B(wd_b), .o_READ_DATA_B(rd_b[k]), .o_READ_VALID_B(rv_b[k])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int l = 0; l < 4; l++) if (we[l]) r[l*8 +: 8] = wd[l*8 +: 8];
    return r;
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] mm [DEPTH];
  int          busy_left = DEPTH;
  bit          model_ok = 1'b0;
  logic        m_coll = 1'b0;
  logic [31:0] pd_a [NI][2];
  logic [31:0] pd_b [NI][2];
  logic        pv_a [NI][2];
  logic        pv_b [NI][2];
  logic [31:0] last_a [NI];
  logic [31:0] last_b [NI];

  // Result a port produces for one cycle's access under a given read mode
  task automatic issue(input int mode, input bit acc, input bit wr, input logic [31:0] old,
                       input logic [31:0] nw, input logic [31:0] last,
                       output bit v, output logic [31:0] d);
    v = 1'b0;
    d = last;
    if (acc) begin
      if (!wr) begin
        v = 1'b1; d = old;
      end else if (mode == 0) begin
        v = 1'b1; d = old;
      end else if (mode == 1) begin
        v = 1'b1; d = nw;
      end
    end
  endtask

  always @(posedge clk) begin
    bit          acc_a, acc_b, wr_a, wr_b, va, vb;
    logic [31:0] old_a, old_b, da, db;
    if (rst) begin
      busy_left = DEPTH;
      m_coll    = 1'b0;
      for (int k = 0; k < NI; k++) begin
        for (int s = 0; s < 2; s++) begin
          pd_a[k][s] = '0; pd_b[k][s] = '0; pv_a[k][s] = 1'b0; pv_b[k][s] = 1'b0;
        end
        last_a[k] = '0; last_b[k] = '0;
      end
      model_ok = 1'b1;
    end else begin
      acc_a = en_a && (busy_left == 0);
      acc_b = en_b && (busy_left == 0);
      wr_a  = (we_a != 0);
      wr_b  = (we_b != 0);
      old_a = mm[addr_a];
      old_b = mm[addr_b];
      for (int k = 0; k < NI; k++) begin
        issue(mode_of(k), acc_a, wr_a, old_a, merge(old_a, wd_a, we_a), last_a[k], va, da);
        issue(mode_of(k), acc_b, wr_b, old_b, merge(old_b, wd_b, we_b), last_b[k], vb, db);
        pd_a[k][1] = pd_a[k][0]; pv_a[k][1] = pv_a[k][0];
        pd_b[k][1] = pd_b[k][0]; pv_b[k][1] = pv_b[k][0];
        pd_a[k][0] = da; pv_a[k][0] = va; last_a[k] = da;
        pd_b[k][0] = db; pv_b[k][0] = vb; last_b[k] = db;
      end
      m_coll = acc_a && acc_b && (addr_a == addr_b) && ((we_a & we_b) != 0);
      if (acc_b && wr_b) mm[addr_b] = merge(mm[addr_b], wd_b, we_b);
      if (acc_a && wr_a) mm[addr_a] = merge(mm[addr_a], wd_a, we_a);
      if (busy_left > 0) begin
        mm[DEPTH - busy_left] = '0;
        busy_left--;
      end
    end
  end

  // Per-cycle comparison of every instance against the model
  always @(negedge clk) begin
    if (model_ok) begin
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("rd_a[%0d]", k), rd_a[k], pd_a[k][lat_of(k)-1]);
        chk($sformatf("rv_a[%0d]", k), 32'(rv_a[k]), 32'(pv_a[k][lat_of(k)-1]));
        chk($sformatf("rd_b[%0d]", k), rd_b[k], pd_b[k][lat_of(k)-1]);
        chk($sformatf("rv_b[%0d]", k), 32'(rv_b[k]), 32'(pv_b[k][lat_of(k)-1]));
        chk($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(busy_left > 0));
        chk($sformatf("coll[%0d]", k), 32'(coll[k]), 32'(m_coll));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    en_a = 1'b0; en_b = 1'b0; we_a = '0; we_b = '0;
  endtask

  task automatic wait_clear(input string nm);
    int n;
    n = 0;
    while (busy[0] && n < 40) begin
      chk({nm, "_rd3"}, rd_a[3], 32'h0);
      chk({nm, "_rv0"}, 32'(rv_a[0]), 32'h0);
      tick();
      n++;
    end
    chk({nm, "_busy_cycles"}, 32'(n), 32'd16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int nvalid;
    idle();
    repeat (3) tick();
    chk("rst_busy", 32'(busy[0]), 32'h1);
    chk("rst_rd", rd_a[3], 32'h0);
    chk("rst_coll", 32'(coll[0]), 32'h0);

    // Release reset with an access pending that must be dropped while busy
    rst = 1'b0;
    en_a = 1'b1; we_a = 4'hF; addr_a = 4'd2; wd_a = 32'hDEADBEEF;
    en_b = 1'b1; addr_b = 4'd9;
    wait_clear("clr");
    idle();

    // All words read back as zero at latency 1
    for (int i = 0; i < DEPTH; i++) begin
      en_a = 1'b1; addr_a = 4'(i);
      en_b = 1'b1; addr_b = 4'(15 - i);
      tick();
      chk("clr_rd_a", rd_a[0], 32'h0);
      chk("clr_rv_a", 32'(rv_a[0]), 32'h1);
      chk("clr_rd_b", rd_b[1], 32'h0);
    end
    idle();
    tick();
    chk("idle_rv", 32'(rv_a[0]), 32'h0);

    // Byte-lane write then cross-port read
    en_a = 1'b1; we_a = 4'hF; addr_a = 4'd3; wd_a = 32'hAABBCCDD;
    tick();
    we_a = 4'b0101; wd_a = 32'h11223344;
    tick();
    idle();
    en_b = 1'b1; addr_b = 4'd3;
    tick();
    chk("lane_rd_b", rd_b[0], 32'hAA22CC44);
    idle();

    // Read-during-write at address 5 holding 1
    en_a = 1'b1; we_a = 4'hF; addr_a = 4'd5; wd_a = 32'h1;
    tick();
    wd_a = 32'h2;
    en_b = 1'b1; addr_b = 4'd5;
    tick();
    idle();
    chk("rdw_rf", rd_a[0], 32'h1);
    chk("rdw_wf", rd_a[1], 32'h2);
    chk("rdw_nc_rd", rd_a[2], 32'h0);
    chk("rdw_nc_rv", 32'(rv_a[2]), 32'h0);
    for (int k = 0; k < 3; k++) chk("rdw_b", rd_b[k], 32'h1);

    // Full-lane collision: A wins
    en_a = 1'b1; we_a = 4'hF; addr_a = 4'd7; wd_a = 32'hFFFF0000;
    en_b = 1'b1; we_b = 4'hF; addr_b = 4'd7; wd_b = 32'h0000FFFF;
    tick();
    idle();
    chk("coll_pulse", 32'(coll[0]), 32'h1);
    en_a = 1'b1; addr_a = 4'd7;
    tick();
    chk("coll_gone", 32'(coll[0]), 32'h0);
    chk("coll_mem", rd_a[0], 32'hFFFF0000);
    // Disjoint lanes: both land, no collision
    en_a = 1'b1; we_a = 4'b1100; addr_a = 4'd7; wd_a = 32'hFFFF0000;
    en_b = 1'b1; we_b = 4'b0011; addr_b = 4'd7; wd_b = 32'h0000FFFF;
    tick();
    idle();
    chk("disj_coll", 32'(coll[0]), 32'h0);
    en_a = 1'b1; addr_a = 4'd7;
    tick();
    chk("disj_mem", rd_a[0], 32'hFFFFFFFF);
    idle();

    // Streaming through the output register
    for (int i = 0; i < 8; i++) begin
      en_a = 1'b1; we_a = 4'hF; addr_a = 4'(i); wd_a = 32'h100 + 32'(i);
      tick();
    end
    idle();
    tick();
    nvalid = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        en_a = 1'b1; addr_a = 4'(i);
      end else idle();
      tick();
      if (rv_a[3]) nvalid++;
      chk("strm_rv", 32'(rv_a[3]), 32'(i >= 1 && i <= 8));
      if (i >= 1 && i <= 8) chk("strm_rd", rd_a[3], 32'h100 + 32'(i - 1));
    end
    chk("strm_count", 32'(nvalid), 32'd8);

    // In-flight read flushed by reset
    en_a = 1'b1; addr_a = 4'd0;
    tick();
    idle();
    rst = 1'b1;
    tick();
    chk("flush_rv3", 32'(rv_a[3]), 32'h0);
    chk("flush_rd3", rd_a[3], 32'h0);

    // Reset again when the clear counter reaches 9
    rst = 1'b0;
    repeat (9) begin
      tick();
      chk("mid_busy", 32'(busy[0]), 32'h1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_clear("reclr");
    en_a = 1'b1; addr_a = 4'd0;
    en_b = 1'b1; addr_b = 4'd7;
    tick();
    idle();
    chk("reclr_a0", rd_a[0], 32'h0);
    chk("reclr_b7", rd_b[0], 32'h0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
